// File: rtl/conv_cmd_issuer_if.sv
// Command/status bundle between the host-side sequencer and its surroundings:
// run request in, accelerator Control/State handshake, progress and error flags out.
interface conv_cmd_issuer_if #(
    parameter int LAYER_W = 8
);
    logic               start;
    logic [LAYER_W-1:0] num_layers;
    logic               reload_para;
    logic [3:0]         State;
    logic [3:0]         Control;
    logic               busy;
    logic [LAYER_W-1:0] layer_idx;
    logic               para_done;
    logic               layer_done;
    logic               done;
    logic               error;

    modport master (
        output start, num_layers, reload_para, State,
        input  Control, busy, layer_idx, para_done, layer_done, done, error
    );

    modport slave (
        input  start, num_layers, reload_para, State,
        output Control, busy, layer_idx, para_done, layer_done, done, error
    );
endinterface

// File: rtl/conv_cmd_issuer.sv
// Layer sequencer: issues load/compute commands on Control, waits for the
// accelerator's interrupt on State, acknowledges it, and repeats per layer.
module conv_cmd_issuer #(
    parameter int                   LAYER_W        = 8,
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    conv_cmd_issuer_if.slave  bus
);
    localparam logic [3:0] CMD_IDLE = 4'b0000;
    localparam logic [3:0] CMD_PARA = 4'b0001;
    localparam logic [3:0] CMD_COMP = 4'b0010;
    localparam logic [3:0] CMD_ACK  = 4'b1111;

    localparam logic [LAYER_W-1:0]   LAYER_ONE  = {{(LAYER_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WDOG_LIMIT = TIMEOUT_CYCLES - WDOG_ONE;

    typedef enum logic [3:0] {
        S_IDLE, S_P_REQ, S_P_WAIT, S_P_ACK, S_C_REQ, S_C_WAIT, S_C_ACK, S_DONE, S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [TIMEOUT_W-1:0] r_wdog;
    logic [LAYER_W-1:0]   r_num_layers;
    logic                 r_reload;
    logic [LAYER_W-1:0]   r_layer_idx;
    logic [3:0]           r_control;
    logic                 r_busy;
    logic                 r_para_done;
    logic                 r_layer_done;
    logic                 r_done;
    logic                 r_error;

    logic       w_in_hs;
    logic       w_timeout;
    logic       w_last;
    logic       w_start_ok;
    logic       w_para_ack;
    logic       w_layer_ack;
    logic [3:0] w_control;
    logic       w_busy;

    assign w_in_hs   = (r_state inside {S_P_REQ, S_P_WAIT, S_P_ACK, S_C_REQ, S_C_WAIT, S_C_ACK});
    assign w_timeout = w_in_hs && (r_wdog == WDOG_LIMIT);
    assign w_last    = (r_layer_idx == r_num_layers - LAYER_ONE);

    // Watchdog has priority over a State match in every handshake state.
    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_para_ack  = 1'b0;
        w_layer_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_ok = 1'b1;
                    w_next     = (bus.num_layers == '0) ? S_DONE : S_P_REQ;
                end
            end
            S_P_REQ:  if (w_timeout) w_next = S_ERR;
                      else if (bus.State == CMD_PARA) w_next = S_P_WAIT;
            S_P_WAIT: if (w_timeout) w_next = S_ERR;
                      else if (bus.State == CMD_ACK) w_next = S_P_ACK;
            S_P_ACK: begin
                if (w_timeout) w_next = S_ERR;
                else if (bus.State == CMD_IDLE) begin
                    w_para_ack = 1'b1;
                    w_next     = S_C_REQ;
                end
            end
            S_C_REQ:  if (w_timeout) w_next = S_ERR;
                      else if (bus.State == CMD_COMP) w_next = S_C_WAIT;
            S_C_WAIT: if (w_timeout) w_next = S_ERR;
                      else if (bus.State == CMD_ACK) w_next = S_C_ACK;
            S_C_ACK: begin
                if (w_timeout) w_next = S_ERR;
                else if (bus.State == CMD_IDLE) begin
                    w_layer_ack = 1'b1;
                    if (w_last)        w_next = S_DONE;
                    else if (r_reload) w_next = S_P_REQ;
                    else               w_next = S_C_REQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they register with it.
    always_comb begin
        w_control = CMD_IDLE;
        w_busy    = 1'b0;
        case (w_next)
            S_P_REQ:  begin w_control = CMD_PARA; w_busy = 1'b1; end
            S_P_WAIT: w_busy = 1'b1;
            S_P_ACK:  begin w_control = CMD_ACK;  w_busy = 1'b1; end
            S_C_REQ:  begin w_control = CMD_COMP; w_busy = 1'b1; end
            S_C_WAIT: w_busy = 1'b1;
            S_C_ACK:  begin w_control = CMD_ACK;  w_busy = 1'b1; end
            default:  begin w_control = CMD_IDLE; w_busy = 1'b0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wdog       <= '0;
            r_layer_idx  <= '0;
            r_control    <= CMD_IDLE;
            r_busy       <= 1'b0;
            r_para_done  <= 1'b0;
            r_layer_done <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_control    <= w_control;
            r_busy       <= w_busy;
            r_para_done  <= w_para_ack;
            r_layer_done <= w_layer_ack;
            r_done       <= (r_state == S_DONE);
            if (w_next != r_state) r_wdog <= '0;
            else if (w_in_hs)      r_wdog <= r_wdog + WDOG_ONE;
            else                   r_wdog <= '0;
            if (w_start_ok)             r_error <= 1'b0;
            else if (w_next == S_ERR)   r_error <= 1'b1;
            if (w_start_ok)                    r_layer_idx <= '0;
            else if (w_layer_ack && !w_last)   r_layer_idx <= r_layer_idx + LAYER_ONE;
        end
    end

    // Run configuration needs no reset: it is only consulted after a start captures it.
    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_num_layers <= bus.num_layers;
            r_reload     <= bus.reload_para;
        end
    end

    assign bus.Control    = r_control;
    assign bus.busy       = r_busy;
    assign bus.layer_idx  = r_layer_idx;
    assign bus.para_done  = r_para_done;
    assign bus.layer_done = r_layer_done;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_conv_cmd_issuer.sv
// Bench for conv_cmd_issuer: reactive accelerator model, event scoreboard,
// table of whole-run vectors and hand sequences for watchdog, busy-start and reset.
module tb_conv_cmd_issuer;
    localparam int LW = 8;
    localparam int K_CTRL = 0, K_PARA = 1, K_LD = 2, K_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_cmd_issuer_if #(.LAYER_W(LW)) bus ();

    conv_cmd_issuer #(.LAYER_W(LW), .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int            kind;
        logic [3:0]    val;
        logic [LW-1:0] idx;
    } ev_t;

    typedef struct {
        int n; int r; int lp; int lc; int hold;
        int exp_para; int exp_ld; int min_ack;
    } vec_t;

    ev_t sb_q[$];
    int  tests = 0;
    int  fails = 0;

    int  cnt_para, cnt_ld, cnt_done, ack_run, ack_run_max;
    int  cyc = 0, ld_cyc, done_cyc;
    logic [3:0] prev_ctrl = 4'h0;
    bit  sb_en = 1'b0;

    // accelerator model knobs and state
    int  m_lp, m_lc, m_hold;
    bit  m_hang, m_clear;
    logic [3:0] acc;
    int  m_cnt, m_hcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ev(input int kind, input logic [3:0] val);
        ev_t e;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got kind=%0d val=%h idx=%0d, expected no event (t=%0t)",
                     kind, val, bus.layer_idx, $time);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.val != val || e.idx != bus.layer_idx) begin
                fails++;
                $display("FAIL sb_event: got kind=%0d val=%h idx=%0d, expected kind=%0d val=%h idx=%0d (t=%0t)",
                         kind, val, bus.layer_idx, e.kind, e.val, e.idx, $time);
            end
        end
    endtask

    task automatic push(input int kind, input logic [3:0] val, input int idx);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.idx  = idx[LW-1:0];
        sb_q.push_back(e);
    endtask

    // Expected event stream of a complete run, in monitor order within a cycle.
    task automatic exp_run(input int n, input int r);
        if (n == 0) begin
            push(K_DONE, 4'h0, 0);
        end else begin
            push(K_CTRL, 4'h1, 0);
            for (int i = 0; i < n; i++) begin
                if (i == 0 || r != 0) begin
                    push(K_CTRL, 4'h0, i);
                    push(K_CTRL, 4'hF, i);
                    push(K_CTRL, 4'h2, i);
                    push(K_PARA, 4'h0, i);
                end
                push(K_CTRL, 4'h0, i);
                push(K_CTRL, 4'hF, i);
                if (i == n - 1) begin
                    push(K_CTRL, 4'h0, i);
                    push(K_LD,   4'h0, i);
                    push(K_DONE, 4'h0, i);
                end else begin
                    push(K_CTRL, (r != 0) ? 4'h1 : 4'h2, i + 1);
                    push(K_LD,   4'h0, i + 1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (m_clear) begin
            acc = 4'h0; m_cnt = 0; m_hcnt = 0;
            bus.State = 4'h0;
        end else begin
            bus.State = acc;
            case (acc)
                4'h0: begin
                    if (bus.Control == 4'h1)      begin acc = 4'h1; m_cnt = m_lp; end
                    else if (bus.Control == 4'h2) begin acc = 4'h2; m_cnt = m_lc; end
                end
                4'h1: if (m_cnt == 0) acc = 4'hF; else m_cnt--;
                4'h2: if (!m_hang) begin
                          if (m_cnt == 0) acc = 4'hF; else m_cnt--;
                      end
                4'hF: if (bus.Control == 4'hF) begin
                          if (m_hcnt >= m_hold) begin acc = 4'h0; m_hcnt = 0; end
                          else m_hcnt++;
                      end
                default: acc = 4'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (sb_en && !rst) begin
            if (bus.Control != prev_ctrl) check_ev(K_CTRL, bus.Control);
            if (bus.para_done)  begin cnt_para++; check_ev(K_PARA, 4'h0); end
            if (bus.layer_done) begin cnt_ld++; ld_cyc = cyc; check_ev(K_LD, 4'h0); end
            if (bus.done)       begin cnt_done++; done_cyc = cyc; check_ev(K_DONE, 4'h0); end
        end
        prev_ctrl = bus.Control;
        if (bus.Control == 4'hF) begin
            ack_run++;
            if (ack_run > ack_run_max) ack_run_max = ack_run;
        end else begin
            ack_run = 0;
        end
    end

    task automatic model_setup(input int lp, input int lc, input int hold, input bit hang);
        m_lp = lp; m_lc = lc; m_hold = hold; m_hang = hang;
        m_clear = 1'b1;
        @(negedge clk);
        @(posedge clk);
        m_clear = 1'b0;
    endtask

    task automatic reset_counts();
        cnt_para = 0; cnt_ld = 0; cnt_done = 0;
        ack_run_max = 0; ld_cyc = 0; done_cyc = 0;
    endtask

    task automatic launch(input int n, input int r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_layers = n[LW-1:0];
        bus.reload_para = r[0];
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.num_layers = '0;
    endtask

    task automatic wait_ctrl(input logic [3:0] v);
        bit ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #2;
            if (bus.Control == v) begin ok = 1'b1; break; end
        end
        chk("wait_ctrl", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_done(input int n, input int exp_para, input int exp_ld);
        for (int c = 0; c < 3000 && cnt_done == 0; c++) begin
            @(posedge clk); #2;
        end
        repeat (3) begin @(posedge clk); #2; end
        chk("done_count", cnt_done, 1);
        chk("para_count", cnt_para, exp_para);
        chk("layer_count", cnt_ld, exp_ld);
        chk("end_error", bus.error, 0);
        chk("end_busy", bus.busy, 0);
        chk("end_control", bus.Control, 0);
        chk("sb_leftover", sb_q.size(), 0);
        if (n > 0) chk("done_lag", done_cyc - ld_cyc, 1);
    endtask

    vec_t vec[6];
    int   k;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_layers = '0;
        bus.reload_para = 1'b0;
        m_lp = 1; m_lc = 1; m_hold = 0; m_hang = 1'b0; m_clear = 1'b1;

        vec[0] = '{1, 1, 1, 2, 0, 1, 1, 1};
        vec[1] = '{3, 0, 2, 1, 0, 1, 3, 1};
        vec[2] = '{3, 1, 0, 0, 1, 3, 3, 1};
        vec[3] = '{0, 1, 0, 0, 0, 0, 0, 0};
        vec[4] = '{2, 0, 1, 3, 5, 1, 2, 5};
        vec[5] = '{4, 1, 3, 0, 2, 4, 4, 2};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_control", bus.Control, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_layer_idx", bus.layer_idx, 0);
        chk("rst_para_done", bus.para_done, 0);
        chk("rst_layer_done", bus.layer_done, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        @(negedge clk);
        rst = 1'b0;
        m_clear = 1'b0;
        sb_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            model_setup(vec[v].lp, vec[v].lc, vec[v].hold, 1'b0);
            reset_counts();
            exp_run(vec[v].n, vec[v].r);
            launch(vec[v].n, vec[v].r);
            wait_done(vec[v].n, vec[v].exp_para, vec[v].exp_ld);
            if (vec[v].n > 0)
                chk("ack_hold_run", {31'd0, ack_run_max >= vec[v].min_ack}, 32'd1);
        end

        // zero layers: done one cycle after acceptance, nothing else moves
        model_setup(1, 1, 0, 1'b0);
        reset_counts();
        push(K_DONE, 4'h0, 0);
        launch(0, 1);
        chk("zero_busy_t0", bus.busy, 0);
        chk("zero_ctrl_t0", bus.Control, 0);
        chk("zero_done_t0", bus.done, 0);
        @(posedge clk); #2;
        chk("zero_done_t1", bus.done, 1);
        chk("zero_busy_t1", bus.busy, 0);
        chk("zero_ctrl_t1", bus.Control, 0);
        @(posedge clk); #2;
        chk("zero_done_t2", bus.done, 0);
        chk("zero_sb_leftover", sb_q.size(), 0);

        // watchdog: compute interrupt never arrives
        model_setup(1, 0, 0, 1'b1);
        reset_counts();
        push(K_CTRL, 4'h1, 0);
        push(K_CTRL, 4'h0, 0);
        push(K_CTRL, 4'hF, 0);
        push(K_CTRL, 4'h2, 0);
        push(K_PARA, 4'h0, 0);
        push(K_CTRL, 4'h0, 0);
        launch(1, 1);
        wait_ctrl(4'h2);
        wait_ctrl(4'h0);
        k = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #2;
            k++;
            if (bus.error) break;
        end
        chk("wdog_cycles", k, 16);
        chk("wdog_error", bus.error, 1);
        chk("wdog_busy", bus.busy, 0);
        chk("wdog_control", bus.Control, 0);
        @(posedge clk); #2;
        chk("wdog_error_sticky", bus.error, 1);
        chk("wdog_layer_count", cnt_ld, 0);
        chk("wdog_sb_leftover", sb_q.size(), 0);
        model_setup(1, 1, 0, 1'b0);
        reset_counts();
        exp_run(1, 1);
        launch(1, 1);
        chk("restart_error_clear", bus.error, 0);
        chk("restart_busy", bus.busy, 1);
        chk("restart_control", bus.Control, 4'h1);
        wait_done(1, 1, 1);

        // start pulse during compute wait is ignored
        model_setup(1, 6, 0, 1'b0);
        reset_counts();
        exp_run(2, 0);
        launch(2, 0);
        wait_ctrl(4'h2);
        wait_ctrl(4'h0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_layers = 8'd7;
        bus.reload_para = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.num_layers = '0;
        wait_done(2, 1, 2);

        // reset in the second layer's parameter acknowledge
        model_setup(1, 1, 4, 1'b0);
        reset_counts();
        exp_run(3, 1);
        launch(3, 1);
        for (int c = 0; c < 500 && cnt_ld == 0; c++) begin
            @(posedge clk); #2;
        end
        wait_ctrl(4'hF);
        chk("pre_rst_idx", bus.layer_idx, 1);
        sb_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("mid_rst_control", bus.Control, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_layer_idx", bus.layer_idx, 0);
        chk("mid_rst_para_done", bus.para_done, 0);
        chk("mid_rst_layer_done", bus.layer_done, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_error", bus.error, 0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        model_setup(1, 1, 0, 1'b0);
        sb_en = 1'b1;
        reset_counts();
        exp_run(1, 1);
        launch(1, 1);
        wait_done(1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
